// File: rtl/int_scheduler.sv
// int_scheduler: machine-level interrupt arbitration and trap tracking
// for the hardisc core.
module int_scheduler #(
   parameter int SYNC_STAGES = 2,
   parameter bit UCE_NMI     = 1'b1
) (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic        s_msip_i,
   input  logic        s_mtip_i,
   input  logic        s_meip_i,
   input  logic        s_uce_i,
   input  logic        s_fcer_i,
   input  logic        s_lcer_i,
   input  logic        s_fuce_i,
   input  logic        s_luce_i,
   input  logic        s_ruce_i,
   input  logic [31:0] s_mie_i,
   input  logic        s_gie_i,
   input  logic        s_ack_i,
   input  logic        s_mret_i,
   output logic        s_int_req_o,
   output logic [4:0]  s_int_cause_o,
   output logic [31:0] s_mip_o,
   output logic        s_in_trap_o
);

   localparam logic [31:0] UC_MASK = 32'h0039_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      TRAP
   } state_t;

   state_t      state_q;
   logic        nest_q;
   logic [2:0]  sync_q [SYNC_STAGES];
   logic [2:0]  ext_lvl;
   logic [5:0]  sticky_q;
   logic [5:0]  events;
   logic [5:0]  ack_clr;
   logic        ack_hit;
   logic [31:0] mip;
   logic [31:0] gate;
   logic [31:0] elig;
   logic        win_any;
   logic        uc_any;
   logic [4:0]  win_cause;
   logic [4:0]  uc_cause;

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= {s_meip_i, s_mtip_i, s_msip_i};
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign ext_lvl = sync_q[SYNC_STAGES-1];

   assign events = {s_ruce_i, s_luce_i, s_fuce_i,
                    s_lcer_i, s_fcer_i, s_uce_i};

   assign ack_hit = (state_q == REQ) && s_ack_i;

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < 6; i++) begin
         if (ack_hit && (s_int_cause_o == 5'(16 + i))) begin
            ack_clr[i] = 1'b1;
         end
      end
   end

   // a pulse in the ack cycle re-arms the bit it would have cleared
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= (sticky_q & ~ack_clr) | events;
      end
   end

   assign mip = {10'b0, sticky_q, 4'b0,
                 ext_lvl[2], 3'b0,
                 ext_lvl[1], 3'b0,
                 ext_lvl[0], 3'b0};

   assign s_mip_o = mip;

   assign gate = s_gie_i ? '1 :
                 (UCE_NMI ? UC_MASK : '0);

   assign elig    = mip & s_mie_i & gate;
   assign win_any = |elig;
   assign uc_any  = UCE_NMI &&
                    (elig[21] || elig[20] ||
                     elig[19] || elig[16]);

   always_comb begin
      win_cause = 5'd0;
      if      (elig[21]) win_cause = 5'd21;
      else if (elig[20]) win_cause = 5'd20;
      else if (elig[19]) win_cause = 5'd19;
      else if (elig[16]) win_cause = 5'd16;
      else if (elig[18]) win_cause = 5'd18;
      else if (elig[17]) win_cause = 5'd17;
      else if (elig[11]) win_cause = 5'd11;
      else if (elig[3])  win_cause = 5'd3;
      else if (elig[7])  win_cause = 5'd7;
   end

   always_comb begin
      uc_cause = 5'd16;
      if      (elig[21]) uc_cause = 5'd21;
      else if (elig[20]) uc_cause = 5'd20;
      else if (elig[19]) uc_cause = 5'd19;
   end

   // nest_q marks a handler interrupted by an uncorrectable source
   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q       <= IDLE;
         nest_q        <= 1'b0;
         s_int_req_o   <= 1'b0;
         s_int_cause_o <= '0;
         s_in_trap_o   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (win_any) begin
                  s_int_cause_o <= win_cause;
                  s_int_req_o   <= 1'b1;
                  state_q       <= REQ;
               end
            end
            REQ: begin
               if (s_ack_i) begin
                  s_int_req_o <= 1'b0;
                  s_in_trap_o <= 1'b1;
                  state_q     <= TRAP;
               end else if (!elig[s_int_cause_o]) begin
                  s_int_req_o <= 1'b0;
                  nest_q      <= 1'b0;
                  state_q     <= nest_q ? TRAP : IDLE;
               end
            end
            TRAP: begin
               if (s_mret_i) begin
                  if (nest_q) begin
                     nest_q <= 1'b0;
                  end else begin
                     s_in_trap_o <= 1'b0;
                     state_q     <= IDLE;
                  end
               end else if (!nest_q && uc_any) begin
                  s_int_cause_o <= uc_cause;
                  s_int_req_o   <= 1'b1;
                  nest_q        <= 1'b1;
                  state_q       <= REQ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_scheduler.sv
// tb_int_scheduler: directed test-plan steps followed by random traffic,
// all cycles compared against a cause-list reference model.
module tb_int_scheduler;

   localparam int SYNC = 2;
   localparam bit NMI  = 1'b1;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        msip = 0, mtip = 0, meip = 0;
   logic        uce = 0, fcer = 0, lcer = 0;
   logic        fuce = 0, luce = 0, ruce = 0;
   logic [31:0] mie = '0;
   logic        gie = 0, ack = 0, mret = 0;
   logic        req;
   logic [4:0]  cause;
   logic [31:0] mip;
   logic        in_trap;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   int_scheduler #(
      .SYNC_STAGES(SYNC),
      .UCE_NMI    (NMI)
   ) dut (
      .s_clk_i      (clk),
      .s_resetn_i   (rstn),
      .s_msip_i     (msip),
      .s_mtip_i     (mtip),
      .s_meip_i     (meip),
      .s_uce_i      (uce),
      .s_fcer_i     (fcer),
      .s_lcer_i     (lcer),
      .s_fuce_i     (fuce),
      .s_luce_i     (luce),
      .s_ruce_i     (ruce),
      .s_mie_i      (mie),
      .s_gie_i      (gie),
      .s_ack_i      (ack),
      .s_mret_i     (mret),
      .s_int_req_o  (req),
      .s_int_cause_o(cause),
      .s_mip_o      (mip),
      .s_in_trap_o  (in_trap)
   );

   // reference model: line history queue, sticky flags per cause,
   // a request flag and a count of active handlers
   logic [2:0] m_q[$];
   bit         m_st [16:21];
   bit         m_req;
   int         m_cause;
   int         m_depth;
   int         prio [9] = '{21, 20, 19, 16, 18, 17, 11, 3, 7};

   function automatic bit is_uc(int c);
      return c == 16 || c == 19 || c == 20 || c == 21;
   endfunction

   function automatic logic [31:0] m_mip();
      logic [31:0] p = '0;
      p[3]  = m_q[0][0];
      p[7]  = m_q[0][1];
      p[11] = m_q[0][2];
      for (int c = 16; c <= 21; c++) p[c] = m_st[c];
      return p;
   endfunction

   function automatic bit m_elig(int c);
      logic [31:0] p = m_mip();
      return p[c] && mie[c] && (gie || (NMI && is_uc(c)));
   endfunction

   task automatic model_reset();
      m_q.delete();
      for (int k = 0; k < SYNC; k++) m_q.push_back(3'b000);
      for (int c = 16; c <= 21; c++) m_st[c] = 0;
      m_req = 0;
      m_cause = 0;
      m_depth = 0;
   endtask

   task automatic model_edge();
      bit any = 0, uany = 0;
      int top = 0, utop = 0, clr = -1;
      bit pul [16:21];
      for (int i = 0; i < 9; i++) begin
         if (m_elig(prio[i])) begin
            if (!any) top = prio[i];
            any = 1;
            if (is_uc(prio[i]) && !uany) begin
               utop = prio[i];
               uany = 1;
            end
         end
      end
      if (m_req) begin
         if (ack) begin
            if (m_cause >= 16) clr = m_cause;
            m_depth++;
            m_req = 0;
         end else if (!m_elig(m_cause)) begin
            m_req = 0;
         end
      end else if (m_depth > 0) begin
         if (mret) m_depth--;
         else if (m_depth == 1 && NMI && uany) begin
            m_req = 1;
            m_cause = utop;
         end
      end else if (any) begin
         m_req = 1;
         m_cause = top;
      end
      pul[16] = uce;  pul[17] = fcer; pul[18] = lcer;
      pul[19] = fuce; pul[20] = luce; pul[21] = ruce;
      for (int c = 16; c <= 21; c++) begin
         if (clr == c) m_st[c] = 0;
         if (pul[c]) m_st[c] = 1;
      end
      m_q.push_back({meip, mtip, msip});
      void'(m_q.pop_front());
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rstn) model_reset();
      else model_edge();
      #1;
      chk("req", 32'(req), 32'(m_req));
      chk("cause", 32'(cause), 32'(m_cause));
      chk("in_trap", 32'(in_trap), 32'(m_depth > 0));
      chk("mip", mip, m_mip());
      uce = 0; fcer = 0; lcer = 0;
      fuce = 0; luce = 0; ruce = 0;
      ack = 0; mret = 0;
   endtask

   task automatic do_reset();
      rstn = 0;
      msip = 0; mtip = 0; meip = 0;
      mie = '0; gie = 0;
      #1;
      chk("rst_req", 32'(req), 0);
      chk("rst_cause", 32'(cause), 0);
      chk("rst_trap", 32'(in_trap), 0);
      chk("rst_mip", mip, 0);
      model_reset();
      step();
      step();
      rstn = 1;
   endtask

   initial begin
      model_reset();
      #2;
      chk("por_req", 32'(req), 0);
      chk("por_trap", 32'(in_trap), 0);
      chk("por_mip", mip, 0);
      step();
      step();
      rstn = 1;

      // timer line through the synchronizer
      mie = 32'h80; gie = 1; mtip = 1;
      step();
      chk("t1_wait1", 32'(req), 0);
      step();
      chk("t1_wait2", 32'(req), 0);
      step();
      chk("t1_req", 32'(req), 1);
      chk("t1_cause", 32'(cause), 7);
      chk("t1_mip", mip, 32'h80);
      do_reset();

      // NMI path with global enable off
      mie = 32'h160000; gie = 0; fcer = 1; luce = 1;
      step();
      step();
      chk("t2_req", 32'(req), 1);
      chk("t2_cause", 32'(cause), 20);
      ack = 1;
      step();
      chk("t2_mip", mip, 32'h20000);
      chk("t2_trap", 32'(in_trap), 1);
      mret = 1;
      step();
      repeat (3) step();
      chk("t2_nogie", 32'(req), 0);
      do_reset();

      // external line dropped before ack
      mie = 32'h800; gie = 1; meip = 1;
      repeat (3) step();
      chk("t3_req", 32'(req), 1);
      chk("t3_cause", 32'(cause), 11);
      meip = 0;
      step();
      step();
      chk("t3_hold", 32'(req), 1);
      step();
      chk("t3_drop", 32'(req), 0);
      repeat (3) step();
      chk("t3_idle", 32'(req), 0);
      do_reset();

      // no preemption, then re-arbitration after mret
      mie = 32'h880; gie = 1; mtip = 1;
      repeat (3) step();
      chk("t4_cause7", 32'(cause), 7);
      meip = 1;
      repeat (4) step();
      chk("t4_frozen", 32'(cause), 7);
      chk("t4_frozen_req", 32'(req), 1);
      ack = 1;
      step();
      mtip = 0;
      repeat (3) step();
      mret = 1;
      step();
      chk("t4_gap", 32'(req), 0);
      chk("t4_gap_trap", 32'(in_trap), 0);
      step();
      chk("t4_req", 32'(req), 1);
      chk("t4_cause11", 32'(cause), 11);
      do_reset();

      // pulse wins over ack of the same cause
      mie = 32'h40000; gie = 1; lcer = 1;
      step();
      step();
      chk("t5_cause", 32'(cause), 18);
      ack = 1; lcer = 1;
      step();
      chk("t5_mip", mip, 32'h40000);
      chk("t5_trap", 32'(in_trap), 1);
      mret = 1;
      step();
      step();
      chk("t5_again", 32'(req), 1);
      chk("t5_cause2", 32'(cause), 18);
      do_reset();

      // nested uncorrectable request inside a handler
      mie = 32'h200080; gie = 1; mtip = 1;
      repeat (3) step();
      ack = 1;
      step();
      ruce = 1;
      step();
      step();
      chk("t6_nreq", 32'(req), 1);
      chk("t6_ncause", 32'(cause), 21);
      chk("t6_ntrap", 32'(in_trap), 1);
      ack = 1;
      step();
      mret = 1;
      step();
      chk("t6_mret1", 32'(in_trap), 1);
      mret = 1;
      step();
      chk("t6_mret2", 32'(in_trap), 0);
      do_reset();

      // random traffic
      mie = 32'h003F_0888; gie = 1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 699) == 0) begin
            do_reset();
            mie = 32'h003F_0888;
            gie = 1;
         end
         if ($urandom_range(0, 49) == 0)
            mie = ($urandom | $urandom) &
                  (($urandom_range(0, 3) == 0) ?
                   32'hFFFF_FFFF : 32'h003F_0888);
         if ($urandom_range(0, 29) == 0)
            gie = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 19) == 0) msip = ~msip;
         if ($urandom_range(0, 19) == 0) mtip = ~mtip;
         if ($urandom_range(0, 19) == 0) meip = ~meip;
         uce  = ($urandom_range(0, 39) == 0);
         fcer = ($urandom_range(0, 39) == 0);
         lcer = ($urandom_range(0, 39) == 0);
         fuce = ($urandom_range(0, 39) == 0);
         luce = ($urandom_range(0, 39) == 0);
         ruce = ($urandom_range(0, 39) == 0);
         ack  = m_req ? ($urandom_range(0, 3) == 0)
                      : ($urandom_range(0, 15) == 0);
         mret = (m_depth > 0 && !m_req)
                ? ($urandom_range(0, 5) == 0)
                : ($urandom_range(0, 29) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
